// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the 8-bit CPU bus: loadable program ROM,
// data RAM, one output register and CPU reset sequencing.
module cpu_mem_responder #(
   parameter int          ROM_DEPTH = 256,
   parameter logic [12:0] RAM_BASE  = 13'h1800,
   parameter int          RAM_DEPTH = 256,
   parameter logic [12:0] IO_ADDR   = 13'h1FFF,
   parameter int          RST_HOLD  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [12:0] addr,
   input  logic        rd,
   input  logic        wr,
   inout  wire  [7:0]  data,
   input  logic        load_valid,
   input  logic [7:0]  load_data,
   input  logic        load_last,
   output logic        load_ready,
   input  logic        reload,
   output logic        cpu_rst,
   output logic [7:0]  io_out,
   output logic        io_strobe,
   output logic        bus_err
);

   localparam int AW = $clog2(ROM_DEPTH);
   localparam int RW = $clog2(RAM_DEPTH);
   localparam int HW = $clog2(RST_HOLD + 1);
   localparam logic [AW-1:0] PTR_MAX  = AW'(ROM_DEPTH - 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(RST_HOLD - 1);
   localparam logic [13:0]   ROM_END  = 14'(ROM_DEPTH);
   localparam logic [13:0]   RAM_LO   = {1'b0, RAM_BASE};
   localparam logic [13:0]   RAM_END  = RAM_LO + 14'(RAM_DEPTH);

   typedef enum logic [1:0] {LOAD, START, RUN} state_t;

   state_t        state, state_nx;
   logic [AW-1:0] load_ptr, ptr_nx;
   logic [HW-1:0] hold_cnt, hold_nx;
   logic [7:0]    rdata, rd_val;
   logic          wr_q;

   logic [7:0] rom [ROM_DEPTH];
   logic [7:0] ram [RAM_DEPTH];

   logic is_io, is_rom, is_ram, is_unm;
   logic in_run, rd_op, wr_op, load_hs;
   logic [AW-1:0] rom_idx;
   logic [RW-1:0] ram_idx;

   // IO_ADDR wins over any region it might fall inside
   assign is_io   = (addr == IO_ADDR);
   assign is_rom  = !is_io && ({1'b0, addr} < ROM_END);
   assign is_ram  = !is_io && !is_rom &&
                    ({1'b0, addr} >= RAM_LO) && ({1'b0, addr} < RAM_END);
   assign is_unm  = !(is_io || is_rom || is_ram);
   assign rom_idx = addr[AW-1:0];
   assign ram_idx = addr[RW-1:0] - RAM_BASE[RW-1:0];

   assign in_run  = (state == RUN);
   assign rd_op   = in_run && rd && !wr;
   assign wr_op   = in_run && wr && !wr_q;
   assign load_hs = (state == LOAD) && load_valid && load_ready;

   assign data = rd_op ? rdata : 8'hzz;

   always_comb begin
      state_nx = state;
      ptr_nx   = load_ptr;
      hold_nx  = hold_cnt;
      unique case (state)
         LOAD: begin
            if (load_hs) begin
               ptr_nx = load_ptr + 1'b1;
               if (load_last || load_ptr == PTR_MAX)
                  state_nx = START;
            end
         end
         START: begin
            if (hold_cnt == HOLD_MAX) begin
               state_nx = RUN;
               hold_nx  = '0;
            end else begin
               hold_nx = hold_cnt + 1'b1;
            end
         end
         RUN: begin
            if (reload) begin
               state_nx = LOAD;
               ptr_nx   = '0;
            end
         end
         default: state_nx = LOAD;
      endcase
   end

   always_comb begin
      rd_val = 8'h00;
      unique case (1'b1)
         is_io:   rd_val = io_out;
         is_rom:  rd_val = rom[rom_idx];
         is_ram:  rd_val = ram[ram_idx];
         default: rd_val = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= LOAD;
         load_ptr   <= '0;
         hold_cnt   <= '0;
         cpu_rst    <= 1'b1;
         load_ready <= 1'b0;
         wr_q       <= 1'b0;
         rdata      <= 8'h00;
         io_out     <= 8'h00;
         io_strobe  <= 1'b0;
         bus_err    <= 1'b0;
      end else begin
         state      <= state_nx;
         load_ptr   <= ptr_nx;
         hold_cnt   <= hold_nx;
         cpu_rst    <= (state_nx != RUN);
         load_ready <= (state_nx == LOAD);
         wr_q       <= wr;
         io_strobe  <= wr_op && is_io;
         if (rd_op)
            rdata <= rd_val;
         if (wr_op && is_io)
            io_out <= data;
         if (in_run && reload)
            bus_err <= 1'b0;
         else if ((wr_op && (is_rom || is_unm)) ||
                  (in_run && rd && wr) ||
                  (rd_op && is_unm))
            bus_err <= 1'b1;
      end
   end

   // arrays carry no reset so loaded bytes survive rst
   always_ff @(posedge clk) begin
      if (load_hs)
         rom[load_ptr] <= load_data;
   end

   always_ff @(posedge clk) begin
      if (wr_op && is_ram)
         ram[ram_idx] <= data;
   end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: load, reset hold, RAM/IO/ROM
// access, error flag, ROM overflow and async reset.
module tb_cpu_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [12:0] addr;
   logic        rd, wr;
   logic [7:0]  drv;
   logic        drv_en;
   wire  [7:0]  data;
   logic        load_valid;
   logic [7:0]  load_data;
   logic        load_last;
   logic        load_ready;
   logic        reload;
   logic        cpu_rst;
   logic [7:0]  io_out;
   logic        io_strobe;
   logic        bus_err;

   int checks = 0;
   int errors = 0;

   assign data = drv_en ? drv : 8'hzz;

   always #5 clk = ~clk;

   cpu_mem_responder dut (
      .clk(clk), .rst(rst), .addr(addr), .rd(rd), .wr(wr),
      .data(data), .load_valid(load_valid), .load_data(load_data),
      .load_last(load_last), .load_ready(load_ready),
      .reload(reload), .cpu_rst(cpu_rst), .io_out(io_out),
      .io_strobe(io_strobe), .bus_err(bus_err)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic load_byte(input logic [7:0] b, input logic last);
      bit ok = 0;
      load_valid = 1'b1;
      load_data  = b;
      load_last  = last;
      for (int k = 0; k < 20; k++) begin
         if (load_ready) begin
            @(negedge clk);
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) check("load_timeout", 0, 1);
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic rd_byte(input logic [12:0] a, input logic [7:0] exp,
                          input string tag);
      addr = a; rd = 1'b1; wr = 1'b0;
      @(negedge clk);
      check(tag, data, exp);
      rd = 1'b0;
   endtask

   // first cycle drives v, later cycles drive ~v to expose re-commits
   task automatic wr_byte(input logic [12:0] a, input logic [7:0] v,
                          input int n, output int strobes);
      strobes = 0;
      addr = a; drv = v; drv_en = 1'b1; wr = 1'b1;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (io_strobe) strobes++;
         drv = ~v;
      end
      wr = 1'b0; drv_en = 1'b0;
      @(negedge clk);
      if (io_strobe) strobes++;
   endtask

   task automatic wait_run();
      int n = 0;
      while (cpu_rst && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("run_wait", cpu_rst, 0);
   endtask

   logic [7:0] t1_bytes [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};

   initial begin
      int s, n, acc, stall;
      rst = 1'b0; addr = '0; rd = 0; wr = 0; drv = '0; drv_en = 0;
      load_valid = 0; load_data = '0; load_last = 0; reload = 0;

      repeat (2) @(negedge clk);
      check("rst_cpu_rst", cpu_rst, 1);
      check("rst_load_ready", load_ready, 0);
      check("rst_io_out", io_out, 8'h00);
      check("rst_io_strobe", io_strobe, 0);
      check("rst_bus_err", bus_err, 0);
      check("rst_hiz", data === 8'hzz, 1);

      rst = 1'b1;
      @(negedge clk);
      check("ready_after_rst", load_ready, 1);
      rd = 1'b1;
      #1 check("load_rd_hiz", data === 8'hzz, 1);
      rd = 1'b0;

      for (int i = 0; i < 4; i++) load_byte(t1_bytes[i], i == 3);
      check("ready_drop", load_ready, 0);
      n = 0;
      while (cpu_rst && n < 20) begin
         n++;
         @(negedge clk);
      end
      check("hold_cycles", n, 4);
      for (int i = 0; i < 4; i++) rd_byte(13'(i), t1_bytes[i], "rom_read");

      wr_byte(13'h1805, 8'h5A, 3, s);
      rd_byte(13'h1805, 8'h5A, "ram_single_commit");
      check("ram_no_err", bus_err, 0);

      wr_byte(13'h1FFF, 8'h3C, 3, s);
      check("io_strobe_count", s, 1);
      check("io_out", io_out, 8'h3C);
      rd_byte(13'h1FFF, 8'h3C, "io_read");
      check("io_no_err", bus_err, 0);

      wr_byte(13'h0002, 8'h99, 1, s);
      check("rom_wr_err", bus_err, 1);
      rd_byte(13'h0002, 8'hC2, "rom_unchanged");
      rd_byte(13'h1000, 8'h00, "unmapped_read");
      repeat (3) @(negedge clk);
      check("err_sticky", bus_err, 1);
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      check("reload_err_clr", bus_err, 0);
      check("reload_cpu_rst", cpu_rst, 1);
      check("reload_ready", load_ready, 1);

      acc = 0; stall = 0;
      for (int c = 0; c < 400; c++) begin
         load_valid = 1'b1;
         load_data  = acc[7:0];
         if (load_ready) acc++;
         else if (acc > 0) stall++;
         if (stall >= 44) break;
         @(negedge clk);
      end
      load_valid = 1'b0;
      check("overflow_accepted", acc, 256);
      wait_run();
      rd_byte(13'h0000, 8'h00, "ovf_rom0");
      rd_byte(13'h0003, 8'h03, "ovf_rom3");
      rd_byte(13'h00FF, 8'hFF, "ovf_rom255");
      check("ovf_no_err", bus_err, 0);
      rd_byte(13'h0100, 8'h00, "rom_end_unmapped");
      check("rom_end_err", bus_err, 1);

      rst = 1'b0;
      #1 rst = 1'b1;
      @(negedge clk);
      load_byte(8'hEE, 0);
      load_byte(8'hFF, 0);
      rst = 1'b0;
      #1;
      check("midload_ready", load_ready, 0);
      check("midload_cpu_rst", cpu_rst, 1);
      check("midload_err", bus_err, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      load_byte(8'h11, 0);
      load_byte(8'h22, 0);
      load_byte(8'h33, 0);
      load_byte(8'h44, 1);
      wait_run();
      rd_byte(13'h0000, 8'h11, "reload_ptr0");
      rd_byte(13'h0003, 8'h44, "reload_ptr3");
      rd_byte(13'h0004, 8'h04, "rom_retained");

      wr_byte(13'h1FFF, 8'hA5, 1, s);
      check("io_out2", io_out, 8'hA5);
      rd_byte(13'h1000, 8'h00, "unmapped2");
      addr = 13'h0000; rd = 1'b1;
      @(negedge clk);
      check("run_rd_data", data, 8'h11);
      rst = 1'b0;
      #1;
      check("midrun_hiz", data === 8'hzz, 1);
      check("midrun_cpu_rst", cpu_rst, 1);
      check("midrun_io_out", io_out, 8'h00);
      check("midrun_err", bus_err, 0);
      check("midrun_ready", load_ready, 0);
      rd = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
Memory-side responder for the 8-bit CPU bus, which carries a 13-bit addr, an 8-bit bidirectional data bus and rd/wr strobes. The block holds a program ROM that is loaded through a byte-stream port, a data RAM, and one memory-mapped output register. It sequences the CPU's reset: the CPU stays in reset until the program load completes and a hold period expires. It sits beside the CPU at the top level, on the opposite end of the addr/data/rd/wr interface.

Parameters:
ROM_DEPTH, 256, bytes of program ROM mapped at 13'h0000..ROM_DEPTH-1
RAM_BASE, 13'h1800, base address of data RAM
RAM_DEPTH, 256, bytes of data RAM
IO_ADDR, 13'h1FFF, address of the output register
RST_HOLD, 4, clk cycles cpu_rst stays high after loading ends (minimum 1)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  asynchronous, active-low reset
addr  in  13  CPU bus address
rd  in  1  CPU read strobe, active-high
wr  in  1  CPU write strobe, active-high
data  inout  8  CPU data bus; driven only as specified below, otherwise 8'hzz
load_valid  in  1  loader byte valid
load_data  in  8  loader byte
load_last  in  1  marks the final loader byte
load_ready  out  1  block accepts a loader byte this cycle
reload  in  1  1-cycle pulse in RUN that restarts program loading
cpu_rst  out  1  active-high reset to the CPU
io_out  out  8  output register
io_strobe  out  1  1-cycle pulse on each write to IO_ADDR
bus_err  out  1  sticky error flag, cleared only by rst or reload

Behaviour:
- Reset (rst=0, async): state=LOAD, load_ptr=0, hold_cnt=0, cpu_rst=1, load_ready=0, io_out=8'h00, io_strobe=0, bus_err=0, rdata=8'h00, wr_q=0. Memory arrays are not reset.
- States: LOAD -> START -> RUN; RUN -> LOAD on reload.
- LOAD:
  - load_ready=1 (registered; asserts 1 cycle after rst deasserts). cpu_rst=1. data is hi-Z and rd/wr are ignored.
  - A handshake is load_valid & load_ready. It writes rom[load_ptr] <= load_data, then load_ptr <= load_ptr+1.
  - If the handshake has load_last=1, or load_ptr==ROM_DEPTH-1, go to START; load_ready drops the next cycle.
  - Bytes offered after the ROM is full are never accepted.
- START: cpu_rst=1 and hold_cnt counts up. When hold_cnt==RST_HOLD-1, go to RUN and clear hold_cnt. cpu_rst=0 from the first RUN cycle.
- RUN, read:
  - Each posedge with rd=1 and wr=0 sets rdata to the byte at addr: ROM, RAM (addr-RAM_BASE), io_out at IO_ADDR, or 8'h00 if unmapped.
  - data = rdata whenever rd=1 & wr=0 & state==RUN. Latency is 1 clk after addr/rd are stable.
- RUN, write:
  - A write commits once per strobe, on the first posedge with wr=1 & wr_q=0 (wr_q is wr registered).
  - RAM addresses write ram. IO_ADDR sets io_out <= data and io_strobe=1 for exactly one cycle.
  - A ROM address or an unmapped address is ignored and sets bus_err=1.
- Simultaneous rd & wr in RUN: the write rule applies, data is not driven, and bus_err=1.
- An unmapped read sets bus_err=1.
- reload in RUN: next state LOAD, load_ptr=0, cpu_rst=1, bus_err cleared. io_out and memory are retained. reload outside RUN is ignored.
- rst asserted mid-load or mid-run: immediate return to the reset values. Previously loaded bytes stay in the array until they are overwritten.
- Address decode uses the full 13 bits. Regions must not overlap; IO_ADDR has priority.

Test Plan:
1. After rst release, stream 4 bytes A0,B1,C2,D3 with load_last on D3 -> load_ready falls, cpu_rst stays 1 for exactly 4 more clks, then 0; reading addr 0..3 in RUN returns A0,B1,C2,D3 with 1-clk latency.
2. In RUN, write 8'h5A to 13'h1805 with wr held for 3 clks, then read 13'h1805 -> single commit, read returns 5A, bus_err=0.
3. Write 8'h3C to 13'h1FFF -> io_out=3C, io_strobe high exactly 1 clk; read 13'h1FFF returns 3C.
4. Write to 13'h0002 (ROM), then read 13'h1000 (unmapped) -> ROM byte unchanged, read returns 00, bus_err=1 and stays 1; a reload pulse clears it and re-enters LOAD with cpu_rst=1.
5. Stream 300 bytes without load_last -> exactly 256 accepted, then START; byte 256 is never acknowledged.
6. Assert rst mid-load after 2 bytes and mid-run with rd=1 -> all outputs at reset values immediately, data hi-Z, load_ptr restarts at 0.
